// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int SRAM_AW           = 18;
  localparam int SRAM_DW           = 16;
  localparam int DEFAULT_BASE_ADDR = 1024;

  // Width of a counter that must hold values 0..cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/mem_sram_phase_cnt.sv
// Loadable down-counter that times one halfword phase of an SRAM access.
// zero is asserted when the count has reached 0, i.e. on the last cycle of a phase.
module mem_sram_phase_cnt #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  // Load takes priority over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: runs each 32-bit load/store as two 16-bit
// SRAM phases (low halfword, then high halfword) and holds ready low meanwhile.
// Optional feature: define MEM_SRAM_RDBUF_EN to add a one-entry word buffer that
// answers repeated loads of the last accessed word without an SRAM cycle.
module mem_stage_sram_ctrl
  import mips_mem_pkg::*;
#(
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic [31:0]         ALU_Res,
  input  logic [31:0]         ST_Val,
  output logic                ready,
  output logic [31:0]         rd_data,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic [SRAM_DW-1:0]  SRAM_DQ_OUT,
  input  logic [SRAM_DW-1:0]  SRAM_DQ_IN,
  output logic                SRAM_DQ_OE,
  output logic                SRAM_WE_N
);

  localparam int             CW         = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0]  CNT_RELOAD = CW'(WAIT_CYCLES - 1);

  mem_state_t           state;
  mem_state_t           state_next;
  logic                 req;
  logic                 rd_hit;
  logic                 start;
  logic                 ready_c;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic                 in_phase;
  logic [16:0]          word_in;
  logic [16:0]          word_q;
  logic                 op_wr_q;
  logic [31:0]          st_val_q;
  logic [31:0]          rd_data_q;
  logic [SRAM_AW-1:0]   addr_q;

  assign req     = MEM_R_EN | MEM_W_EN;
  assign word_in = 17'((ALU_Res - 32'(BASE_ADDR)) >> 2);

`ifdef MEM_SRAM_RDBUF_EN
  logic        buf_valid;
  logic [16:0] buf_word;
  logic [31:0] buf_data;

  assign rd_hit = (state == IDLE) && MEM_R_EN && !MEM_W_EN &&
                  buf_valid && (buf_word == word_in);

  // Remember the word touched by the last completed access, whether read or written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_word  <= '0;
      buf_data  <= '0;
    end else if (state == DONE) begin
      buf_valid <= 1'b1;
      buf_word  <= word_q;
      buf_data  <= op_wr_q ? st_val_q : rd_data_q;
    end
  end

  assign rd_data = rd_hit ? buf_data : rd_data_q;
`else
  assign rd_hit  = 1'b0;
  assign rd_data = rd_data_q;
`endif

  assign start = (state == IDLE) && req && !rd_hit;

  mem_sram_phase_cnt #(
    .WIDTH (CW)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_RELOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register; an asynchronous reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, phase counter control and the pipeline freeze signal.
  always_comb begin
    state_next = state;
    ready_c    = 1'b1;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LO;
          ready_c    = 1'b0;
          cnt_load   = 1'b1;
        end
      end
      LO: begin
        ready_c = 1'b0;
        if (cnt_zero) begin
          state_next = HI;
          cnt_load   = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HI: begin
        ready_c = 1'b0;
        if (cnt_zero) begin
          state_next = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ready = ready_c | ~rst;

  // Latch the request at acceptance, advance the halfword address and collect read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr_q   <= 1'b0;
      word_q    <= '0;
      st_val_q  <= '0;
      rd_data_q <= '0;
      addr_q    <= '0;
    end else begin
      if (start) begin
        op_wr_q  <= MEM_W_EN;
        word_q   <= word_in;
        st_val_q <= ST_Val;
        addr_q   <= {word_in, 1'b0};
      end
      if ((state == LO) && cnt_zero) begin
        addr_q <= {word_q, 1'b1};
        if (!op_wr_q) begin
          rd_data_q[15:0] <= SRAM_DQ_IN;
        end
      end
      if ((state == HI) && cnt_zero && !op_wr_q) begin
        rd_data_q[31:16] <= SRAM_DQ_IN;
      end
`ifdef MEM_SRAM_RDBUF_EN
      if (rd_hit) begin
        rd_data_q <= buf_data;
      end
`endif
    end
  end

  assign in_phase    = (state == LO) || (state == HI);
  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_OUT = (state == HI) ? st_val_q[31:16] : st_val_q[15:0];
  assign SRAM_DQ_OE  = in_phase & op_wr_q;
  assign SRAM_WE_N   = ~(in_phase & op_wr_q);

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl with a behavioural SRAM, a word-level
// reference memory and a scoreboard consumed by an independent monitor.
module tb_mem_stage_sram_ctrl;

  localparam int W       = 2;
  localparam int BASE    = 1024;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] alu_res = '0;
  logic [31:0] st_val = '0;
  logic        ready;
  logic [31:0] rd_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in = '0;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MEM_R_EN    (mem_r_en),
    .MEM_W_EN    (mem_w_en),
    .ALU_Res     (alu_res),
    .ST_Val      (st_val),
    .ready       (ready),
    .rd_data     (rd_data),
    .SRAM_ADDR   (sram_addr),
    .SRAM_DQ_OUT (sram_dq_out),
    .SRAM_DQ_IN  (sram_dq_in),
    .SRAM_DQ_OE  (sram_dq_oe),
    .SRAM_WE_N   (sram_we_n)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural SRAM: unwritten halfwords hold an address-derived pattern.
  logic [15:0] sram_mem [int];

  function automatic logic [15:0] init_hw(input int ha);
    return 16'(ha * 40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] sram_read(input logic [17:0] a);
    if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
    return init_hw(int'(a));
  endfunction

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[int'(sram_addr)] = sram_dq_out;
  end

  always @(negedge clk) begin
    sram_dq_in <= sram_read(sram_addr);
  end

  // Word-level reference model.
  logic [31:0] ref_mem [int];
  logic [31:0] model_rd = '0;
  logic [17:0] model_addr = '0;
  bit          buf_valid = 1'b0;
  int          buf_word = 0;

  function automatic int word_of(input logic [31:0] a);
    return int'(((a - 32'(BASE)) >> 2) & 32'h1FFFF);
  endfunction

  function automatic logic [31:0] ref_read(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return {init_hw(2 * w + 1), init_hw(2 * w)};
  endfunction

  typedef struct {
    bit          is_wr;
    logic [31:0] st;
    logic [17:0] lo_addr;
    logic [31:0] exp_rd;
    int          exp_len;
  } txn_t;

  txn_t sb[$];
  bit   mon_off = 1'b1;

  // Must be entered just after a rising edge; leaves with the request dropped just after a rising edge.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    int   w;
    bit   hit;
    int   n;
    w = word_of(addr);
`ifdef MEM_SRAM_RDBUF_EN
    hit = buf_valid && (buf_word == w) && rd && !wr;
`else
    hit = 1'b0;
`endif
    t.is_wr   = wr;
    t.st      = data;
    t.lo_addr = 18'(2 * w);
    if (wr) begin
      ref_mem[w] = data;
      t.exp_rd   = model_rd;
    end else begin
      t.exp_rd = ref_read(w);
      model_rd = t.exp_rd;
    end
    t.exp_len = hit ? 1 : 2 * W + 2;
    if (!hit) begin
      model_addr = t.lo_addr | 18'd1;
      buf_valid  = 1'b1;
      buf_word   = w;
    end
    sb.push_back(t);
    mem_r_en = rd;
    mem_w_en = wr;
    alu_res  = addr;
    st_val   = data;
    n = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      n++;
      if (n > TIMEOUT) begin
        failures++;
        $display("[TB] FAIL ready_timeout: ready still 0 after %0d cycles, expected 1 by cycle %0d", n, t.exp_len);
        sb.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  // Monitor: checks every cycle against the oldest scoreboard entry or the idle expectation.
  int cyc = 0;
  always @(negedge clk) begin
    txn_t t;
    if (!rst || mon_off) begin
      cyc = 0;
    end else if (!(mem_r_en || mem_w_en)) begin
      cyc = 0;
      checkOutput("idle_ready", 32'(ready), 32'd1);
      checkOutput("idle_we_n", 32'(sram_we_n), 32'd1);
      checkOutput("idle_oe", 32'(sram_dq_oe), 32'd0);
      checkOutput("idle_addr", 32'(sram_addr), 32'(model_addr));
      checkOutput("idle_rd_data", rd_data, model_rd);
    end else if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: request active, expected an entry, got none");
    end else begin
      cyc++;
      t = sb[0];
      if (cyc == 1) begin
        checkOutput("req_ready", 32'(ready), (t.exp_len == 1) ? 32'd1 : 32'd0);
        checkOutput("req_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("req_oe", 32'(sram_dq_oe), 32'd0);
      end else if (cyc <= W + 1) begin
        checkOutput("lo_ready", 32'(ready), 32'd0);
        checkOutput("lo_addr", 32'(sram_addr), 32'(t.lo_addr));
        checkOutput("lo_we_n", 32'(sram_we_n), 32'(!t.is_wr));
        checkOutput("lo_oe", 32'(sram_dq_oe), 32'(t.is_wr));
        if (t.is_wr) checkOutput("lo_dq_out", 32'(sram_dq_out), 32'(t.st[15:0]));
      end else if (cyc <= 2 * W + 1) begin
        checkOutput("hi_ready", 32'(ready), 32'd0);
        checkOutput("hi_addr", 32'(sram_addr), 32'(t.lo_addr | 18'd1));
        checkOutput("hi_we_n", 32'(sram_we_n), 32'(!t.is_wr));
        checkOutput("hi_oe", 32'(sram_dq_oe), 32'(t.is_wr));
        if (t.is_wr) checkOutput("hi_dq_out", 32'(sram_dq_out), 32'(t.st[31:16]));
      end else begin
        checkOutput("done_ready", 32'(ready), 32'd1);
        checkOutput("done_addr", 32'(sram_addr), 32'(t.lo_addr | 18'd1));
        checkOutput("done_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("done_oe", 32'(sram_dq_oe), 32'd0);
      end
      if (ready) begin
        checkOutput("latency", 32'(cyc), 32'(t.exp_len));
        checkOutput("rd_data", rd_data, t.exp_rd);
        void'(sb.pop_front());
        cyc = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          op;
    $display("[TB] start, WAIT_CYCLES=%0d BASE_ADDR=%0d", W, BASE);
    #1;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("reset_oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("reset_addr", 32'(sram_addr), 32'd0);
    checkOutput("reset_dq_out", 32'(sram_dq_out), 32'd0);
    checkOutput("reset_rd_data", rd_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_off = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    applyStimulus(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'd1040, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 32'd1040, 32'h0);

    // Reset in the middle of the high phase of a load.
    mon_off  = 1'b1;
    mem_r_en = 1'b1;
    alu_res  = 32'd1032;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("abort_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("abort_oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("abort_rd_data", rd_data, 32'd0);
    checkOutput("abort_ready", 32'(ready), 32'd1);
    mem_r_en   = 1'b0;
    model_rd   = '0;
    model_addr = '0;
    buf_valid  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_off = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      op = int'($urandom_range(0, 9));
      if (op < 5)      applyStimulus(1'b1, 1'b0, a, 32'h0);
      else if (op < 9) applyStimulus(1'b0, 1'b1, a, $urandom);
      else             applyStimulus(1'b1, 1'b1, a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
